// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Byte-addressable 32-bit data memory for the load/store path. It supports
//   RV32I LB/LH/LW/LBU/LHU/SB/SH/SW with a valid/ready request handshake and
//   a one-cycle response. It also detects misalignment, range and funct3
//   faults, and can run an optional post-reset sweep that zeroes every word.
//
// Parameters
//   ADDR_WIDTH     : word-address bits (DEPTH = 2**ADDR_WIDTH words)
//   CLEAR_ON_RESET : 1 = zero all words after reset before accepting requests
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   funct3              : RV32I load/store funct3
//   address, write_data : byte address, store data
//   resp_valid          : one-cycle pulse for the previously accepted request
//   read_data           : extended load result (0 for stores and faults)
//   misaligned_fault, range_fault, funct3_fault : fault flags for the response
module data_memory_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        misaligned_fault,
  output logic        range_fault,
  output logic        funct3_fault
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic                  f3_bad;
  logic                  mis;
  logic                  rng;
  logic                  any_fault;
  logic                  st_we;
  logic [3:0]            byte_en;
  logic [31:0]           wr_lanes;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_val;

  always_comb begin
    word_idx = address[ADDR_WIDTH+1:2];
    lane     = address[1:0];
    // rst gates acceptance so a request in the reset cycle never writes
    accept   = req_valid && req_ready && !rst;

    if (req_write) f3_bad = (funct3 > 3'd2);
    else           f3_bad = (funct3 == 3'd3) || (funct3 > 3'd5);

    // funct3[1:0] is the access width: 00 byte, 01 half, 10 word
    mis = ((funct3[1:0] == 2'b01) && address[0]) ||
          ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
    rng = |address[31:ADDR_WIDTH+2];
    any_fault = f3_bad || mis || rng;
    st_we     = accept && req_write && !any_fault;

    case (funct3[1:0])
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = address[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase

    // Replicate the store data so each enabled lane finds its bytes in place
    case (funct3[1:0])
      2'b00:   wr_lanes = {4{write_data[7:0]}};
      2'b01:   wr_lanes = {2{write_data[15:0]}};
      default: wr_lanes = write_data;
    endcase

    rd_word = mem[word_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = address[1] ? rd_word[31:16] : rd_word[15:0];

    case (funct3)
      3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd4:    load_val = {24'h000000, rd_byte};
      3'd5:    load_val = {16'h0000, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // The memory array has no reset; the clear sweep and stores share one port
  always_ff @(posedge clk) begin
    if (state == INIT && !rst) begin
      mem[clr_cnt] <= '0;
    end else if (st_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= CLEAR_ON_RESET ? INIT : READY;
      req_ready        <= !CLEAR_ON_RESET;
      clr_cnt          <= '0;
      resp_valid       <= 1'b0;
      read_data        <= '0;
      misaligned_fault <= 1'b0;
      range_fault      <= 1'b0;
      funct3_fault     <= 1'b0;
    end else begin
      if (state == INIT) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == '1) begin
          state     <= READY;
          req_ready <= 1'b1;
        end
      end

      resp_valid <= accept;
      if (accept) begin
        misaligned_fault <= mis;
        range_fault      <= rng;
        funct3_fault     <= f3_bad;
        read_data        <= (any_fault || req_write) ? '0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Testbench for data_memory_ctrl. The main instance (CLEAR_ON_RESET=1) is
// checked every cycle against a behavioural byte-array model, and directed
// literal expectations pin that model. A second instance (CLEAR_ON_RESET=0)
// covers the no-clear reset behaviour.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, sweep enabled
  logic        rst, req_valid, req_write, req_ready, resp_valid;
  logic [2:0]  funct3;
  logic [31:0] address, write_data, read_data;
  logic        misaligned_fault, range_fault, funct3_fault;

  // second instance, no sweep
  logic        rst_n, req_valid_n, req_write_n, req_ready_n, resp_valid_n;
  logic [2:0]  funct3_n;
  logic [31:0] address_n, write_data_n, read_data_n;
  logic        misaligned_fault_n, range_fault_n, funct3_fault_n;

  data_memory_ctrl #(.ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .funct3(funct3), .address(address),
    .write_data(write_data), .resp_valid(resp_valid), .read_data(read_data),
    .misaligned_fault(misaligned_fault), .range_fault(range_fault),
    .funct3_fault(funct3_fault)
  );

  data_memory_ctrl #(.ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst_n), .req_valid(req_valid_n), .req_ready(req_ready_n),
    .req_write(req_write_n), .funct3(funct3_n), .address(address_n),
    .write_data(write_data_n), .resp_valid(resp_valid_n), .read_data(read_data_n),
    .misaligned_fault(misaligned_fault_n), .range_fault(range_fault_n),
    .funct3_fault(funct3_fault_n)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  logic [31:0] mmem [256];
  bit          live = 1'b0;
  int          init_left = 0;
  bit          m_ready = 1'b0, m_resp = 1'b0, m_mis = 1'b0, m_rng = 1'b0, m_f3 = 1'b0;
  logic [31:0] m_rd = '0;

  task automatic model_access(input bit w, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] d);
    int unsigned wc, idx, lane, nbytes;
    bit          legal;
    logic [31:0] word, bv, hv;
    wc    = f % 4;
    idx   = (a / 4) % 256;
    lane  = a % 4;
    legal = w ? (f <= 2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    m_mis = (wc == 1 && a % 2 != 0) || (wc == 2 && a % 4 != 0);
    m_rng = (a >= 32'd1024);
    m_f3  = !legal;
    m_rd  = '0;
    if (legal && !m_mis && !m_rng) begin
      if (w) begin
        nbytes = 1 << wc;
        for (int i = 0; i < int'(nbytes); i++)
          mmem[idx][8*(int'(lane)+i) +: 8] = d[8*i +: 8];
      end else begin
        word = mmem[idx];
        bv   = (word >> (8 * lane)) & 32'hFF;
        hv   = (word >> (16 * (lane / 2))) & 32'hFFFF;
        case (f)
          3'd0:    m_rd = (bv >= 128) ? bv - 32'd256 : bv;
          3'd1:    m_rd = (hv >= 32768) ? hv - 32'd65536 : hv;
          3'd4:    m_rd = bv;
          3'd5:    m_rd = hv;
          default: m_rd = word;
        endcase
      end
    end
  endtask

  always @(posedge clk) begin
    bit          r, v, w, acc;
    logic [2:0]  f;
    logic [31:0] a, d;
    r = rst; v = req_valid; w = req_write; f = funct3; a = address; d = write_data;
    if (r === 1'b1) begin
      live = 1'b1; init_left = 256;
      m_resp = 1'b0; m_rd = '0; m_mis = 1'b0; m_rng = 1'b0; m_f3 = 1'b0;
    end else if (live) begin
      acc = v && m_ready;
      if (init_left > 0) begin
        mmem[256 - init_left] = '0;
        init_left--;
      end
      m_resp = acc;
      if (acc) model_access(w, f, a, d);
    end
    m_ready = (init_left == 0);
    #1;
    if (live) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_ready});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_resp});
      chk("read_data", read_data, m_rd);
      chk("misaligned_fault", {31'd0, misaligned_fault}, {31'd0, m_mis});
      chk("range_fault", {31'd0, range_fault}, {31'd0, m_rng});
      chk("funct3_fault", {31'd0, funct3_fault}, {31'd0, m_f3});
    end
  end

  // ---------------- directed helpers ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic xfer(input string name, input bit w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic [2:0] exp_flags);
    req_valid = 1'b1; req_write = w; funct3 = f; address = a; write_data = d;
    @(negedge clk);
    req_valid = 1'b0;
    chk({name, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({name, "_data"}, read_data, exp_rd);
    chk({name, "_flags"}, {29'd0, misaligned_fault, range_fault, funct3_fault},
        {29'd0, exp_flags});
  endtask

  task automatic wait_ready(input string name, input int exp_n);
    int n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, exp_n);
  endtask

  task automatic xfer_nc(input string name, input bit w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd);
    req_valid_n = 1'b1; req_write_n = w; funct3_n = f; address_n = a; write_data_n = d;
    @(negedge clk);
    req_valid_n = 1'b0;
    chk({name, "_valid"}, {31'd0, resp_valid_n}, 32'd1);
    chk({name, "_data"}, read_data_n, exp_rd);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = '0; address = '0; write_data = '0;
    rst_n = 1'b1; req_valid_n = 1'b0; req_write_n = 1'b0; funct3_n = '0; address_n = '0;
    write_data_n = '0;

    // reset and clear sweep
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    wait_ready("sweep_len", 256);

    xfer("lw_000", 1'b0, 3'd2, 32'h000, '0, 32'h0, 3'b000);
    xfer("lw_200", 1'b0, 3'd2, 32'h200, '0, 32'h0, 3'b000);
    xfer("lw_3fc", 1'b0, 3'd2, 32'h3FC, '0, 32'h0, 3'b000);

    // byte/half stores and loads
    xfer("sw_10", 1'b1, 3'd2, 32'h10, 32'h11223344, 32'h0, 3'b000);
    xfer("sb_11", 1'b1, 3'd0, 32'h11, 32'h000000AA, 32'h0, 3'b000);
    xfer("sh_12", 1'b1, 3'd1, 32'h12, 32'h00008001, 32'h0, 3'b000);
    xfer("lw_10", 1'b0, 3'd2, 32'h10, '0, 32'h8001AA44, 3'b000);
    xfer("lb_11", 1'b0, 3'd0, 32'h11, '0, 32'hFFFFFFAA, 3'b000);
    xfer("lbu_11", 1'b0, 3'd4, 32'h11, '0, 32'h000000AA, 3'b000);
    xfer("lh_12", 1'b0, 3'd1, 32'h12, '0, 32'hFFFF8001, 3'b000);
    xfer("lhu_12", 1'b0, 3'd5, 32'h12, '0, 32'h00008001, 3'b000);

    // faults
    xfer("lw_mis", 1'b0, 3'd2, 32'h13, '0, 32'h0, 3'b100);
    xfer("sw_range", 1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 32'h0, 3'b010);
    xfer("lw_000_after", 1'b0, 3'd2, 32'h000, '0, 32'h0, 3'b000);
    xfer("st_f3", 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 32'h0, 3'b001);
    xfer("lw_10_after", 1'b0, 3'd2, 32'h10, '0, 32'h8001AA44, 3'b000);
    xfer("lh_mis_rng", 1'b0, 3'd1, 32'h401, '0, 32'h0, 3'b110);

    // back-to-back store then load
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'd2; address = 32'h20; write_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("b2b_first_valid", {31'd0, resp_valid}, 32'd1);
    req_write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_valid", {31'd0, resp_valid}, 32'd1);
    chk("b2b_second_data", read_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("b2b_idle_valid", {31'd0, resp_valid}, 32'd0);
    chk("b2b_hold_data", read_data, 32'hDEADBEEF);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = 1'($urandom_range(0, 1));
      funct3     = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                 : ((req_write) ? 3'($urandom_range(0, 2))
                                : 3'($urandom_range(0, 4) == 3 ? 5 : $urandom_range(0, 4)));
      case ($urandom_range(0, 9))
        0:       address = $urandom;
        1, 2:    address = $urandom_range(0, 1023);
        default: address = $urandom_range(0, 63);
      endcase
      write_data = $urandom;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // reset in the middle of the sweep restarts it
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_sweep_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("sweep_restart_len", 256);
    xfer("lw_20_cleared", 1'b0, 3'd2, 32'h20, '0, 32'h0, 3'b000);

    // no-clear instance
    rst_n = 1'b0;
    chk("nc_rst_ready", {31'd0, req_ready_n}, 32'd1);
    chk("nc_rst_resp_valid", {31'd0, resp_valid_n}, 32'd0);
    chk("nc_rst_read_data", read_data_n, 32'd0);
    xfer_nc("nc_sw_30", 1'b1, 3'd2, 32'h30, 32'h12345678, 32'h0);
    xfer_nc("nc_lw_30", 1'b0, 3'd2, 32'h30, '0, 32'h12345678);

    // request in the reset cycle is neither accepted nor written
    rst_n = 1'b1; req_valid_n = 1'b1; req_write_n = 1'b1; funct3_n = 3'd2;
    address_n = 32'h30; write_data_n = 32'h5;
    @(negedge clk);
    rst_n = 1'b0; req_valid_n = 1'b0;
    chk("nc_rst_req_valid", {31'd0, resp_valid_n}, 32'd0);
    chk("nc_rst_req_ready", {31'd0, req_ready_n}, 32'd1);
    xfer_nc("nc_lw_30_kept", 1'b0, 3'd2, 32'h30, '0, 32'h12345678);

    // response pending at reset is dropped
    req_valid_n = 1'b1; req_write_n = 1'b0; funct3_n = 3'd0; address_n = 32'h31;
    @(negedge clk);
    rst_n = 1'b1; req_valid_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    chk("nc_drop_valid", {31'd0, resp_valid_n}, 32'd0);
    chk("nc_drop_data", read_data_n, 32'd0);
    xfer_nc("nc_lbu_31", 1'b0, 3'd4, 32'h31, '0, 32'h00000056);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
